// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants, config record and channel-select width helper for multi_clk_div
package div_pkg;

  localparam int DIV_W_DEFAULT = 32;
  localparam int DIV_CH_MAX    = 16;

  typedef struct packed {
    logic [DIV_W_DEFAULT-1:0] div;
    logic                     en;
    logic [DIV_W_DEFAULT-1:0] high;
  } div_cfg_t;

  function automatic int ch_sel_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/div_channel.sv
// rtl/div_channel.sv - one divider channel: counter, shadowed config, pending flag, registered outputs
// Optional programmable high phase when DIV_DUTY_EN is defined.
module div_channel import div_pkg::*; #(
  parameter int W = DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_i,
  input  logic [W-1:0] div_i,
  input  logic         en_i,
`ifdef DIV_DUTY_EN
  input  logic [W-1:0] high_i,
`endif
  output logic         pend_o,
  output logic         wave_o,
  output logic         tick_o,
  output logic         active_o
);

  logic [W-1:0] cnt_q, cnt_d, div_q, div_d, sh_div_q;
  logic         en_q, en_d, sh_en_q, pend_q, pend_d;
  logic         wave_q, wave_d, tick_q, tick_d;
  logic         accept, live, live_d, period_end, apply;
`ifdef DIV_DUTY_EN
  logic [W-1:0] high_q, high_d, sh_high_q;
`endif

  assign accept     = wr_i && !pend_q;
  assign live       = en_q && (div_q != '0);
  assign period_end = live && (cnt_q == div_q - W'(1));
  // An idle channel has no period to protect, so its shadow lands at once.
  assign apply      = pend_q && (period_end || !live);

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    en_d   = en_q;
    pend_d = pend_q;
`ifdef DIV_DUTY_EN
    high_d = high_q;
`endif
    if (accept && !en_i) begin
      en_d   = 1'b0;
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (apply) begin
      div_d  = sh_div_q;
      en_d   = sh_en_q;
`ifdef DIV_DUTY_EN
      high_d = sh_high_q;
`endif
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (live && !period_end) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = '0;
    end
    if (accept && en_i) pend_d = 1'b1;

    // Outputs are computed from next state so they line up with cnt_q.
    live_d = en_d && (div_d != '0);
    tick_d = live_d && (cnt_d == div_d - W'(1));
`ifdef DIV_DUTY_EN
    wave_d = live_d && ((high_d >= div_d) || (cnt_d >= div_d - high_d));
`else
    wave_d = live_d && (cnt_d >= (div_d >> 1));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= '0;
      en_q      <= 1'b0;
      pend_q    <= 1'b0;
      sh_div_q  <= '0;
      sh_en_q   <= 1'b0;
      wave_q    <= 1'b0;
      tick_q    <= 1'b0;
`ifdef DIV_DUTY_EN
      high_q    <= '0;
      sh_high_q <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      en_q   <= en_d;
      pend_q <= pend_d;
      wave_q <= wave_d;
      tick_q <= tick_d;
`ifdef DIV_DUTY_EN
      high_q <= high_d;
`endif
      if (accept && en_i) begin
        sh_div_q  <= div_i;
        sh_en_q   <= en_i;
`ifdef DIV_DUTY_EN
        sh_high_q <= high_i;
`endif
      end
    end
  end

  assign pend_o   = pend_q;
  assign wave_o   = wave_q;
  assign tick_o   = tick_q;
  assign active_o = live;

endmodule

// File: rtl/multi_clk_div.sv
// rtl/multi_clk_div.sv - CH independent clock dividers sharing one config write port
// Define DIV_DUTY_EN to add the cfg_high port and programmable high phase.
module multi_clk_div import div_pkg::*; #(
  parameter  int CH = 4,
  parameter  int W  = DIV_W_DEFAULT,
  localparam int CW = ch_sel_w(CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_div,
  input  logic          cfg_en,
`ifdef DIV_DUTY_EN
  input  logic [W-1:0]  cfg_high,
`endif
  output logic [CH-1:0] wave_out,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] active
);

  logic [CH-1:0] pend;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    div_channel #(.W(W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_i     (cfg_valid && (cfg_ch == CW'(g))),
      .div_i    (cfg_div),
      .en_i     (cfg_en),
`ifdef DIV_DUTY_EN
      .high_i   (cfg_high),
`endif
      .pend_o   (pend[g]),
      .wave_o   (wave_out[g]),
      .tick_o   (tick[g]),
      .active_o (active[g])
    );
  end

  // Selects beyond CH match no channel, so the write is taken and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CH; i++) begin
      if (cfg_ch == CW'(i)) cfg_ready = !pend[i];
    end
  end

endmodule
